uart_tx_stream: RTL and testbench

//  Parametrised UART transmitter with an input FIFO: accepts data words on a valid/ready stream and serialises

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_stream.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and the parity helper.
// Also intended for the parametrised uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int unsigned UART_MAX_DATA_BITS = 9;

    // Callers zero-extend narrower words; the extra zeros do not change the parity.
    function automatic logic parity_bit(input logic [UART_MAX_DATA_BITS-1:0] data,
                                        input parity_e mode);
        case (mode)
            PAR_EVEN: parity_bit = ^data;
            PAR_ODD:  parity_bit = ~^data;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy output. Read data shows the oldest stored word;
// a word written this cycle is never visible at the output in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready stream through an input FIFO.
// Define UART_TX_ERR_INJECT_EN to add the inject_par/inject_frm error-injection ports.
module uart_tx_stream #(
    parameter  int DATA_BITS  = 8,
    parameter  int PARITY     = 1,
    parameter  int STOP_BITS  = 1,
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_WIDTH  = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy,
    output logic [LVL_W-1:0]     fifo_level
`ifdef UART_TX_ERR_INJECT_EN
    ,
    input  logic                 inject_par,
    input  logic                 inject_frm
`endif
);

    import uart_pkg::*;

    localparam int      BIT_W    = $clog2(DATA_BITS);
    localparam parity_e PAR_MODE = parity_e'(2'(PARITY));

    uart_tx_state_e        state_q;
    logic [DIV_WIDTH-1:0]  timer_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [BIT_W-1:0]      bit_idx_q;
    logic                  stop_idx_q;
    logic [DATA_BITS-1:0]  word_q;
    logic                  par_q;
    logic                  frm_err_q;
    logic                  tx_q;
    logic                  busy_q;

    logic [DATA_BITS-1:0]  fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_lvl;
    logic                  pop;
    logic                  tick;
    logic                  last_stop;
    logic                  tx_now;
    logic                  inj_par_w;
    logic                  inj_frm_w;

`ifdef UART_TX_ERR_INJECT_EN
    assign inj_par_w = inject_par && (PARITY != 0);
    assign inj_frm_w = inject_frm;
`else
    assign inj_par_w = 1'b0;
    assign inj_frm_w = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .wr_en_i   (in_valid),
        .wr_data_i (in_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_lvl)
    );

    assign tick      = (timer_q == '0);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    // A word is taken either from idle or at the end of the final stop bit, so frames run gap-free.
    assign pop       = !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == STOP) && tick && last_stop));

    always_comb begin
        tx_now = 1'b1;
        case (state_q)
            START:            tx_now = 1'b0;
            DATA:             tx_now = word_q[bit_idx_q];
            uart_pkg::PARITY: tx_now = par_q;
            STOP:             tx_now = !(frm_err_q && (stop_idx_q == 1'b0));
            default:          tx_now = 1'b1;
        endcase
    end

    // tx and busy are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            word_q     <= '0;
            par_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_q   <= tx_now;
            busy_q <= (state_q != IDLE) || !fifo_empty;

            if (state_q == IDLE) begin
                if (!fifo_empty) begin
                    state_q <= START;
                end
            end else if (!tick) begin
                timer_q <= timer_q - DIV_WIDTH'(1);
            end else begin
                timer_q <= div_q;
                case (state_q)
                    START: begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                    DATA: begin
                        if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                            state_q    <= (PARITY == 0) ? STOP : uart_pkg::PARITY;
                            stop_idx_q <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                    uart_pkg::PARITY: begin
                        state_q    <= STOP;
                        stop_idx_q <= 1'b0;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state_q <= fifo_empty ? IDLE : START;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Frame parameters are captured once per word; later divisor or inject changes wait a frame.
            if (pop) begin
                word_q    <= fifo_rd_data;
                div_q     <= divisor;
                timer_q   <= divisor;
                par_q     <= parity_bit(UART_MAX_DATA_BITS'(fifo_rd_data), PAR_MODE) ^ inj_par_w;
                frm_err_q <= inj_frm_w;
            end
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign in_ready   = !fifo_full;
    assign fifo_level = fifo_lvl;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: default instance plus a 7-bit / odd / 2-stop instance.
// Error-injection checks are compiled only when UART_TX_ERR_INJECT_EN is defined.
module tb_uart_tx_stream;

    logic        clk;
    logic        nreset;
    logic [15:0] divisor;
    logic        in_valid, in_valid3;
    logic [7:0]  in_data;
    logic [6:0]  in_data3;
    logic        in_ready, in_ready3;
    logic        tx0, tx3;
    logic        busy0, busy3;
    logic [4:0]  lvl0;
    logic [2:0]  lvl3;
    logic        inject_par, inject_frm, inj_zero;

    logic        mon_sel;
    wire         tx_mon   = mon_sel ? tx3 : tx0;
    wire         busy_mon = mon_sel ? busy3 : busy0;
    wire  [4:0]  lvl_mon  = mon_sel ? {2'b00, lvl3} : lvl0;

    int n_checks;
    int n_fail;

    uart_tx_stream u_dut (
        .clk        (clk),
        .nreset     (nreset),
        .divisor    (divisor),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx         (tx0),
        .busy       (busy0),
        .fifo_level (lvl0)
`ifdef UART_TX_ERR_INJECT_EN
        ,
        .inject_par (inject_par),
        .inject_frm (inject_frm)
`endif
    );

    uart_tx_stream #(
        .DATA_BITS  (7),
        .PARITY     (2),
        .STOP_BITS  (2),
        .FIFO_DEPTH (4)
    ) u_dut3 (
        .clk        (clk),
        .nreset     (nreset),
        .divisor    (divisor),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .tx         (tx3),
        .busy       (busy3),
        .fifo_level (lvl3)
`ifdef UART_TX_ERR_INJECT_EN
        ,
        .inject_par (inj_zero),
        .inject_frm (inj_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        logic [8:0]  data;
        logic [15:0] div;
        logic [10:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts at cycle 0 of the start bit; returns on the first cycle after the frame.
    task automatic check_bits(input logic [10:0] exp, input int div, input string name);
        for (int b = 0; b < 11; b++) begin
            logic bad;
            logic seen;
            bad  = 1'b0;
            seen = exp[b];
            for (int c = 0; c <= div; c++) begin
                if (tx_mon !== exp[b]) begin
                    bad  = 1'b1;
                    seen = tx_mon;
                end
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", name, b), 32'(bad ? seen : exp[b]), 32'(exp[b]));
        end
    endtask

    // Called at a negedge with the block idle.
    task automatic send_frame(input bit sel, input logic [8:0] data, input logic [15:0] div,
                              input logic [10:0] exp, input string name);
        mon_sel = sel;
        divisor = div;
        if (sel) begin
            in_data3  = data[6:0];
            in_valid3 = 1'b1;
        end else begin
            in_data  = data[7:0];
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        @(negedge clk);
        check({name, " tx high at N+1"}, 32'(tx_mon), 32'd1);
        @(negedge clk);
        check({name, " busy in frame"}, 32'(busy_mon), 32'd1);
        check_bits(exp, int'(div), name);
        check({name, " idle tx"}, 32'(tx_mon), 32'd1);
        check({name, " idle busy"}, 32'(busy_mon), 32'd0);
        check({name, " idle level"}, 32'(lvl_mon), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        nreset     = 1'b0;
        divisor    = 16'd5;
        in_valid   = 1'b0;
        in_valid3  = 1'b0;
        in_data    = '0;
        in_data3   = '0;
        inject_par = 1'b0;
        inject_frm = 1'b0;
        inj_zero   = 1'b0;
        mon_sel    = 1'b0;

        vecs[0] = '{1'b0, 9'h0A5, 16'd5, {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{1'b0, 9'h000, 16'd0, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[2] = '{1'b0, 9'h0FF, 16'd2, {1'b1, 1'b0, 8'hFF, 1'b0}};
        vecs[3] = '{1'b0, 9'h001, 16'd3, {1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[4] = '{1'b0, 9'h080, 16'd1, {1'b1, 1'b1, 8'h80, 1'b0}};
        vecs[5] = '{1'b0, 9'h03C, 16'd7, {1'b1, 1'b0, 8'h3C, 1'b0}};
        vecs[6] = '{1'b1, 9'h07F, 16'd5, {2'b11, 1'b0, 7'h7F, 1'b0}};
        vecs[7] = '{1'b1, 9'h000, 16'd0, {2'b11, 1'b1, 7'h00, 1'b0}};
        vecs[8] = '{1'b1, 9'h055, 16'd2, {2'b11, 1'b1, 7'h55, 1'b0}};

        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx0), 32'd1);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset level", 32'(lvl0), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset tx", 32'(tx0), 32'd1);
        check("post-reset tx3", 32'(tx3), 32'd1);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].div, vecs[i].exp,
                       $sformatf("vec%0d", i));
        end
        mon_sel = 1'b0;

        // Stream of 20 words with valid held: FIFO fills, frames run back to back.
        divisor = 16'd5;
        fork
            begin : pusher
                int  idx;
                int  guard;
                bit  low_seen;
                logic rdy;
                idx = 0;
                guard = 0;
                low_seen = 1'b0;
                while (idx < 20 && guard < 3000) begin
                    in_data  = 8'h30 + 8'(idx);
                    in_valid = 1'b1;
                    rdy = in_ready;
                    if (!rdy && !low_seen) begin
                        low_seen = 1'b1;
                        check("stream accepted before full", 32'(idx), 32'd17);
                        check("stream level when full", 32'(lvl0), 32'd16);
                    end
                    @(negedge clk);
                    if (rdy) idx++;
                    guard++;
                end
                in_valid = 1'b0;
                check("stream all pushed", 32'(idx), 32'd20);
                check("stream saw in_ready low", 32'(low_seen), 32'd1);
            end
            begin : decoder
                int w;
                w = 0;
                while (tx0 !== 1'b0 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check("stream first start", 32'(tx0), 32'd0);
                for (int f = 0; f < 20; f++) begin
                    logic [10:0] rx;
                    logic [7:0]  d;
                    rx = '0;
                    d  = 8'h30 + 8'(f);
                    for (int b = 0; b < 11; b++) begin
                        repeat (3) @(negedge clk);
                        rx[b] = tx0;
                        repeat (3) @(negedge clk);
                    end
                    check($sformatf("stream frame%0d", f), 32'(rx), 32'({1'b1, ^d, d, 1'b0}));
                end
            end
        join
        check("stream end tx", 32'(tx0), 32'd1);
        check("stream end busy", 32'(busy0), 32'd0);
        check("stream end level", 32'(lvl0), 32'd0);

        // Divisor change mid-frame applies from the next frame.
        divisor  = 16'd5;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        check("push+pop level", 32'(lvl0), 32'd1);
        check("div test tx pre-start", 32'(tx0), 32'd1);
        @(negedge clk);
        fork
            begin
                check_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, "div old");
                check_bits({1'b1, 1'b0, 8'hC3, 1'b0}, 11, "div new");
            end
            begin
                repeat (20) @(negedge clk);
                divisor = 16'd11;
            end
        join
        check("div test idle tx", 32'(tx0), 32'd1);
        check("div test idle busy", 32'(busy0), 32'd0);

        // Reset in the middle of a data bit with words queued.
        divisor  = 16'd5;
        in_data  = 8'h00;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("reset test queued", 32'(lvl0), 32'd3);
        repeat (10) @(negedge clk);
        check("reset test tx low in data", 32'(tx0), 32'd0);
        check("reset test busy before", 32'(busy0), 32'd1);
        #2 nreset = 1'b0;
        #1;
        check("async reset tx", 32'(tx0), 32'd1);
        check("async reset level", 32'(lvl0), 32'd0);
        check("async reset busy", 32'(busy0), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        begin
            logic quiet;
            quiet = 1'b1;
            repeat (150) begin
                @(negedge clk);
                if (tx0 !== 1'b1 || busy0 !== 1'b0 || lvl0 !== 5'd0) quiet = 1'b0;
            end
            check("no frames after reset", 32'(quiet), 32'd1);
        end

`ifdef UART_TX_ERR_INJECT_EN
        mon_sel    = 1'b0;
        divisor    = 16'd5;
        inject_par = 1'b1;
        in_data    = 8'h01;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        @(negedge clk);
        inject_par = 1'b0;
        check("inj_par tx pre-start", 32'(tx0), 32'd1);
        @(negedge clk);
        check_bits({1'b1, 1'b0, 8'h01, 1'b0}, 5, "inj_par");
        check("inj_par idle", 32'(tx0), 32'd1);

        inject_frm = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        @(negedge clk);
        inject_frm = 1'b0;
        check("inj_frm tx pre-start", 32'(tx0), 32'd1);
        @(negedge clk);
        check_bits({1'b0, 1'b1, 8'h01, 1'b0}, 5, "inj_frm");
        check("inj_frm idle", 32'(tx0), 32'd1);

        send_frame(1'b0, 9'h001, 16'd5, {1'b1, 1'b1, 8'h01, 1'b0}, "inj cleared");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
